// File: rtl/entry_queue16_145bit_if.sv
// entry_queue16_145bit_if: bundles the handshake and bus signals of the 16-entry, 145-bit queue.
//   Macro QUEUE_FLUSH_EN adds the flush input.
//   master (producer/consumer side) drives: push, wr_data, pop[, flush].
//   master observes: entries, head_ptr, tail_ptr, count, empty, full, err_ovf, err_unf.
//   slave (queue side) takes the opposite directions.
interface entry_queue16_145bit_if #(
  parameter int WIDTH = 145,
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
);
  logic                   push;
  logic [WIDTH-1:0]       wr_data;
  logic                   pop;
`ifdef QUEUE_FLUSH_EN
  logic                   flush;
`endif
  logic [DEPTH*WIDTH-1:0] entries;
  logic [PTR_W-1:0]       head_ptr;
  logic [PTR_W-1:0]       tail_ptr;
  logic [PTR_W:0]         count;
  logic                   empty;
  logic                   full;
  logic                   err_ovf;
  logic                   err_unf;
  modport master (
    output push, wr_data, pop,
`ifdef QUEUE_FLUSH_EN
    output flush,
`endif
    input  entries, head_ptr, tail_ptr, count, empty, full, err_ovf, err_unf
  );
  modport slave (
    input  push, wr_data, pop,
`ifdef QUEUE_FLUSH_EN
    input  flush,
`endif
    output entries, head_ptr, tail_ptr, count, empty, full, err_ovf, err_unf
  );
endinterface

// File: rtl/entry_queue16_145bit.sv
// entry_queue16_145bit: 16-entry circular queue of 145-bit entries feeding a 16:1 selector.
//   Macro QUEUE_FLUSH_EN adds a flush input that empties the queue (data and error flags kept).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   q     : slave modport; push/wr_data/pop[/flush] in; entries, head_ptr (selector select),
//           tail_ptr, count (0..16), empty, full, sticky err_ovf/err_unf out.
module entry_queue16_145bit #(
  parameter int WIDTH = 145,
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  entry_queue16_145bit_if.slave q
);
  logic [WIDTH-1:0] slot_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             empty, full, pop_ok, push_ok, fl, wr_en;
`ifdef QUEUE_FLUSH_EN
  assign fl = q.flush;
`else
  assign fl = 1'b0;
`endif
  assign empty = count_q == '0;
  assign full  = count_q == (PTR_W+1)'(DEPTH);
  // A pop while full frees the head slot, so a simultaneous push may land there.
  always_comb begin
    pop_ok  = q.pop && !empty;
    push_ok = q.push && (!full || q.pop);
    wr_en   = push_ok && !fl;
    head_d  = fl ? '0 : head_q + PTR_W'(pop_ok);
    tail_d  = fl ? '0 : tail_q + PTR_W'(push_ok);
    count_d = fl ? '0 : count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
    ovf_d   = ovf_q | (q.push && !push_ok && !fl);
    unf_d   = unf_q | (q.pop && !pop_ok && !fl);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_en) slot_q[tail_q] <= q.wr_data;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  for (genvar k = 0; k < DEPTH; k++) begin : g_out
    assign q.entries[k*WIDTH +: WIDTH] = slot_q[k];
  end
  assign q.head_ptr = head_q;
  assign q.tail_ptr = tail_q;
  assign q.count    = count_q;
  assign q.empty    = empty;
  assign q.full     = full;
  assign q.err_ovf  = ovf_q;
  assign q.err_unf  = unf_q;
endmodule

// File: tb/tb_entry_queue16_145bit.sv
// tb_entry_queue16_145bit: directed self-checking bench for entry_queue16_145bit.
module tb_entry_queue16_145bit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  entry_queue16_145bit_if qi ();
  entry_queue16_145bit dut (.clk(clk), .rst_n(rst_n), .q(qi));
  always #5 clk = ~clk;
  function automatic logic [144:0] slot(input int k);
    return qi.entries[k*145 +: 145];
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    qi.push = 1'b0;
    qi.pop = 1'b0;
    qi.wr_data = '0;
`ifdef QUEUE_FLUSH_EN
    qi.flush = 1'b0;
`endif
  endtask
  task automatic apply_reset();
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    cyc();
  endtask
  task automatic test_reset();
    idle();
    #2;
    n_cmp++; if (qi.count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", qi.count); end
    n_cmp++; if (qi.empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", qi.empty); end
    n_cmp++; if (qi.full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", qi.full); end
    n_cmp++; if (qi.head_ptr !== 4'd0 || qi.tail_ptr !== 4'd0) begin n_err++; $display("FAIL reset_ptrs got %0d/%0d want 0/0", qi.head_ptr, qi.tail_ptr); end
    n_cmp++; if (qi.err_ovf !== 1'b0 || qi.err_unf !== 1'b0) begin n_err++; $display("FAIL reset_errs got %b%b want 00", qi.err_ovf, qi.err_unf); end
    n_cmp++; if (qi.entries !== '0) begin n_err++; $display("FAIL reset_entries got nonzero want 0"); end
    rst_n = 1'b1;
    cyc();
  endtask
  task automatic test_push_two();
    qi.push = 1'b1; qi.wr_data = 145'h1; cyc();
    qi.wr_data = 145'h2; cyc();
    idle();
    n_cmp++; if (qi.count !== 5'd2) begin n_err++; $display("FAIL push2_count got %0d want 2", qi.count); end
    n_cmp++; if (qi.head_ptr !== 4'd0 || qi.tail_ptr !== 4'd2) begin n_err++; $display("FAIL push2_ptrs got %0d/%0d want 0/2", qi.head_ptr, qi.tail_ptr); end
    n_cmp++; if (slot(0) !== 145'h1 || slot(1) !== 145'h2) begin n_err++; $display("FAIL push2_slots got %0h/%0h want 1/2", slot(0), slot(1)); end
    n_cmp++; if (qi.empty !== 1'b0) begin n_err++; $display("FAIL push2_empty got %b want 0", qi.empty); end
  endtask
  task automatic test_fill_overflow();
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      qi.push = 1'b1; qi.wr_data = 145'(i); cyc();
    end
    idle();
    n_cmp++; if (qi.full !== 1'b1 || qi.count !== 5'd16) begin n_err++; $display("FAIL fill_full got full=%b count=%0d want 1/16", qi.full, qi.count); end
    n_cmp++; if (qi.tail_ptr !== 4'd0) begin n_err++; $display("FAIL fill_tail got %0d want 0", qi.tail_ptr); end
    n_cmp++; if (slot(15) !== 145'd15) begin n_err++; $display("FAIL fill_slot15 got %0h want f", slot(15)); end
    qi.push = 1'b1; qi.wr_data = 145'h77; cyc();
    idle();
    n_cmp++; if (qi.err_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", qi.err_ovf); end
    n_cmp++; if (qi.count !== 5'd16 || qi.tail_ptr !== 4'd0) begin n_err++; $display("FAIL ovf_state got count=%0d tail=%0d want 16/0", qi.count, qi.tail_ptr); end
    n_cmp++; if (slot(0) !== 145'd0) begin n_err++; $display("FAIL ovf_slot0 got %0h want 0", slot(0)); end
    n_cmp++; if (qi.err_unf !== 1'b0) begin n_err++; $display("FAIL ovf_unf got %b want 0", qi.err_unf); end
  endtask
  task automatic test_full_push_pop();
    qi.push = 1'b1; qi.pop = 1'b1; qi.wr_data = 145'hAA; cyc();
    idle();
    n_cmp++; if (qi.head_ptr !== 4'd1 || qi.tail_ptr !== 4'd1) begin n_err++; $display("FAIL fullpp_ptrs got %0d/%0d want 1/1", qi.head_ptr, qi.tail_ptr); end
    n_cmp++; if (qi.count !== 5'd16 || qi.full !== 1'b1) begin n_err++; $display("FAIL fullpp_count got %0d full=%b want 16/1", qi.count, qi.full); end
    n_cmp++; if (slot(0) !== 145'hAA || slot(1) !== 145'd1) begin n_err++; $display("FAIL fullpp_slots got %0h/%0h want aa/1", slot(0), slot(1)); end
  endtask
  task automatic test_underflow();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      qi.push = 1'b1; qi.wr_data = 145'(10 + i); cyc();
    end
    idle();
    for (int i = 0; i < 20; i++) begin
      qi.pop = 1'b1; cyc();
      if (i == 0) begin
        n_cmp++; if (qi.head_ptr !== 4'd1 || slot(qi.head_ptr) !== 145'd11) begin n_err++; $display("FAIL pop1_head got %0d want 1", qi.head_ptr); end
      end
      if (i == 2) begin
        n_cmp++; if (qi.empty !== 1'b1 || qi.head_ptr !== 4'd3) begin n_err++; $display("FAIL pop3 got empty=%b head=%0d want 1/3", qi.empty, qi.head_ptr); end
        n_cmp++; if (qi.err_unf !== 1'b0) begin n_err++; $display("FAIL pop3_unf got %b want 0", qi.err_unf); end
      end
    end
    idle();
    n_cmp++; if (qi.err_unf !== 1'b1) begin n_err++; $display("FAIL unf_flag got %b want 1", qi.err_unf); end
    n_cmp++; if (qi.head_ptr !== 4'd3 || qi.count !== 5'd0) begin n_err++; $display("FAIL unf_state got head=%0d count=%0d want 3/0", qi.head_ptr, qi.count); end
    qi.push = 1'b1; qi.pop = 1'b1; qi.wr_data = 145'h55; cyc();
    idle();
    n_cmp++; if (qi.count !== 5'd1 || qi.head_ptr !== 4'd3 || qi.tail_ptr !== 4'd4) begin n_err++; $display("FAIL emptypp got count=%0d head=%0d tail=%0d want 1/3/4", qi.count, qi.head_ptr, qi.tail_ptr); end
    n_cmp++; if (slot(3) !== 145'h55) begin n_err++; $display("FAIL emptypp_slot got %0h want 55", slot(3)); end
  endtask
  task automatic test_wrap();
    logic [3:0] eh = 4'd3;
    logic wrapped = 1'b0;
    for (int i = 0; i < 40; i++) begin
      qi.push = 1'b1; qi.pop = 1'b1; qi.wr_data = 145'(100 + i); cyc();
      eh = eh + 4'd1;
      if (eh == 4'd0) wrapped = 1'b1;
      n_cmp++; if (qi.count !== 5'd1) begin n_err++; $display("FAIL wrap_count[%0d] got %0d want 1", i, qi.count); end
      n_cmp++; if (qi.head_ptr !== eh || qi.tail_ptr !== eh + 4'd1) begin n_err++; $display("FAIL wrap_ptrs[%0d] got %0d/%0d want %0d/%0d", i, qi.head_ptr, qi.tail_ptr, eh, eh + 4'd1); end
    end
    idle();
    n_cmp++; if (wrapped !== 1'b1 || qi.head_ptr !== 4'd11) begin n_err++; $display("FAIL wrap_end got head=%0d want 11", qi.head_ptr); end
    n_cmp++; if (slot(11) !== 145'd139) begin n_err++; $display("FAIL wrap_oldest got %0d want 139", slot(11)); end
  endtask
  task automatic test_async_reset();
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (qi.count !== 5'd0 || qi.head_ptr !== 4'd0 || qi.tail_ptr !== 4'd0) begin n_err++; $display("FAIL arst_state got count=%0d head=%0d tail=%0d want 0/0/0", qi.count, qi.head_ptr, qi.tail_ptr); end
    n_cmp++; if (qi.err_unf !== 1'b0 || qi.empty !== 1'b1) begin n_err++; $display("FAIL arst_flags got unf=%b empty=%b want 0/1", qi.err_unf, qi.empty); end
    n_cmp++; if (slot(11) !== 145'd0) begin n_err++; $display("FAIL arst_slot got %0h want 0", slot(11)); end
    rst_n = 1'b1;
    cyc();
  endtask
`ifdef QUEUE_FLUSH_EN
  task automatic test_flush();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      qi.push = 1'b1; qi.wr_data = 145'(20 + i); cyc();
    end
    qi.flush = 1'b1; qi.wr_data = 145'h99; cyc();
    idle();
    n_cmp++; if (qi.count !== 5'd0 || qi.head_ptr !== 4'd0 || qi.tail_ptr !== 4'd0) begin n_err++; $display("FAIL flush_state got count=%0d head=%0d tail=%0d want 0/0/0", qi.count, qi.head_ptr, qi.tail_ptr); end
    n_cmp++; if (qi.empty !== 1'b1 || slot(0) !== 145'd20 || slot(5) !== 145'd0) begin n_err++; $display("FAIL flush_data got empty=%b slot0=%0d slot5=%0d want 1/20/0", qi.empty, slot(0), slot(5)); end
  endtask
`endif
  initial begin
    test_reset();
    test_push_two();
    test_fill_overflow();
    test_full_push_pop();
    test_underflow();
    test_wrap();
    test_async_reset();
`ifdef QUEUE_FLUSH_EN
    test_flush();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
